// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned RES_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [RES_W-1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage fields in, stall/flush/forward controls out, between pipeline and hazard unit.
interface hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
);
    logic [REG_AW-1:0] Rs1_D;
    logic [REG_AW-1:0] Rs2_D;
    logic [REG_AW-1:0] Rd_D;
    logic              regWrite_D;
    logic [RES_W-1:0]  resultSrc_D;
    logic              multiCycle_D;
    logic              pcSrc_E;

    logic              stall_F;
    logic              stall_D;
    logic              stall_E;
    logic              flush_D;
    logic              flush_E;
    fwd_sel_t          forwardA_E;
    fwd_sel_t          forwardB_E;
    logic              busy;

    // Pipeline side
    modport master (
        output Rs1_D, Rs2_D, Rd_D, regWrite_D, resultSrc_D, multiCycle_D, pcSrc_E,
        input  stall_F, stall_D, stall_E, flush_D, flush_E, forwardA_E, forwardB_E, busy
    );

    // Hazard unit side
    modport slave (
        input  Rs1_D, Rs2_D, Rd_D, regWrite_D, resultSrc_D, multiCycle_D, pcSrc_E,
        output stall_F, stall_D, stall_E, flush_D, flush_E, forwardA_E, forwardB_E, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Holds a multi-cycle execute op in E for MULDIV_CYCLES-1 cycles, then releases it.
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic multi_cycle_e,
    output logic stall_e,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The release cycle (BUSY, cnt==0) lets the op advance; a following op starts fresh from IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (multi_cycle_e) begin
                    stall_c   = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    stall_c = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign stall_e = stall_c;
    assign busy    = stall_c;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline; tracks its own E/M/W shadow.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    hazard_unit_if.slave hz
);

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic [RES_W-1:0]  result_src;
        logic              multi_cycle;
    } e_stage_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } wb_stage_t;

    e_stage_t  e_q;
    wb_stage_t m_q;
    wb_stage_t w_q;
    e_stage_t  d_fields_c;

    logic stall_e_c;
    logic md_busy_c;
    logic lw_stall_c;
    logic stall_f_c;
    logic stall_d_c;
    logic flush_d_c;
    logic flush_e_c;

    function automatic fwd_sel_t fwd_pick(
        input logic [REG_AW-1:0] rs,
        input wb_stage_t         m,
        input wb_stage_t         w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (w.reg_write && (w.rd != '0) && (w.rd == rs)) sel = FWD_W;
        if (m.reg_write && (m.rd != '0) && (m.rd == rs)) sel = FWD_M;
        return sel;
    endfunction

    muldiv_seq #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_seq (
        .clk           (clk),
        .rst           (rst),
        .multi_cycle_e (e_q.multi_cycle),
        .stall_e       (stall_e_c),
        .busy          (md_busy_c)
    );

    assign d_fields_c = '{
        rs1:         hz.Rs1_D,
        rs2:         hz.Rs2_D,
        rd:          hz.Rd_D,
        reg_write:   hz.regWrite_D,
        result_src:  hz.resultSrc_D,
        multi_cycle: hz.multiCycle_D
    };

    // Load in E feeding a D source; x0 destinations never count.
    assign lw_stall_c = (e_q.result_src == RESULT_LOAD) && e_q.reg_write &&
                        (e_q.rd != '0) &&
                        ((e_q.rd == hz.Rs1_D) || (e_q.rd == hz.Rs2_D));

    // A held multi-cycle op masks both redirects and load-use; redirect beats load-use.
    always_comb begin
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        if (stall_e_c) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
        end else if (hz.pcSrc_E) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
        end else if (lw_stall_c) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
        end
    end

    // Shadow E/M/W: flush bubbles E, a held E bubbles M, W always follows M.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (flush_e_c) begin
                e_q <= '0;
            end else if (!stall_e_c) begin
                e_q <= d_fields_c;
            end
            if (stall_e_c) begin
                m_q <= '0;
            end else begin
                m_q <= '{rd: e_q.rd, reg_write: e_q.reg_write};
            end
            w_q <= m_q;
        end
    end

    assign hz.stall_F    = stall_f_c;
    assign hz.stall_D    = stall_d_c;
    assign hz.stall_E    = stall_e_c;
    assign hz.flush_D    = flush_d_c;
    assign hz.flush_E    = flush_e_c;
    assign hz.busy       = md_busy_c;
    assign hz.forwardA_E = fwd_pick(e_q.rs1, m_q, w_q);
    assign hz.forwardB_E = fwd_pick(e_q.rs2, m_q, w_q);

endmodule
